// File: rtl/onephoto_pkg.sv
// Shared OnePhoto direction-finding constants and types.
// Used by the ring buffer and the cross-correlation delay scanner.
package onephoto_pkg;

    localparam int L           = 32;
    localparam int DELTA_START = 74;
    localparam int DELTA_LAST  = 127;
    localparam int READBIT     = 24;

    localparam int DW = $clog2(DELTA_LAST);
    localparam int IW = $clog2(L);
    localparam int PW = 2 * READBIT;
    localparam int CW = PW + IW;

    typedef logic signed [READBIT-1:0] sample_t;
    typedef logic signed [PW-1:0]      prod_t;
    typedef logic signed [CW-1:0]      corr_t;
    typedef logic [DW-1:0]             delta_t;
    typedef logic [IW-1:0]             index_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_REF,
        S_SCAN,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } state_t;

endpackage

// File: rtl/xcorr_delay_scanner_if.sv
// Scanner bus: start/reference input, ring-buffer read port and results.
// slave is the scanner side, master the ring buffer / controller side.
interface xcorr_delay_scanner_if;
    import onephoto_pkg::*;

    logic    i_start;
    logic    i_ref_valid;
    sample_t i_ref_data;
    delta_t  o_delta;
    index_t  o_index;
    sample_t i_buffer_data;
    delta_t  o_best_delta;
    corr_t   o_best_corr;
    logic    o_done;
    logic    o_busy;

    modport master (
        output i_start, i_ref_valid, i_ref_data, i_buffer_data,
        input  o_delta, o_index, o_best_delta, o_best_corr,
        input  o_done, o_busy
    );

    modport slave (
        input  i_start, i_ref_valid, i_ref_data, i_buffer_data,
        output o_delta, o_index, o_best_delta, o_best_corr,
        output o_done, o_busy
    );

endinterface

// File: rtl/xcorr_delay_scanner_mac_pipe.sv
// Registered signed multiply followed by a full-width accumulator.
// Product width is never truncated; accumulator holds L terms safely.
module mac_pipe
    import onephoto_pkg::*;
(
    input  logic    i_50M_clk,
    input  logic    i_rst,
    input  logic    clr,
    input  logic    en,
    input  sample_t a,
    input  sample_t b,
    output corr_t   acc
);

    prod_t prod;
    logic  prod_vld;

    always_ff @(posedge i_50M_clk or posedge i_rst) begin
        if (i_rst) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            prod_vld <= en;
            if (en)
                prod <= a * b;
            if (clr)
                acc <= '0;
            else if (prod_vld)
                acc <= acc + corr_t'(prod);
        end
    end

endmodule

// File: rtl/xcorr_delay_scanner.sv
// Captures a reference window, sweeps all candidate delays through the
// ring buffer and keeps the delay with the largest cross-correlation.
module xcorr_delay_scanner
    import onephoto_pkg::*;
(
    input  logic                  i_50M_clk,
    input  logic                  i_rst,
    xcorr_delay_scanner_if.slave  bus
);

    state_t  state;
    state_t  state_nx;
    index_t  ref_cnt;
    sample_t ref_mem [L];
    sample_t ref_q;
    logic    scan_d1;
    logic    drain_cnt;
    delta_t  delta_q;
    index_t  index_q;
    delta_t  best_delta;
    corr_t   best_corr;
    corr_t   acc;

    logic load_last;
    logic scan_last;
    logic sweep_last;
    logic first_delta;
    logic acc_clr;

    assign load_last   = (state == S_LOAD_REF) && bus.i_ref_valid
                         && (ref_cnt == IW'(L - 1));
    assign scan_last   = (state == S_SCAN) && (index_q == IW'(L - 1));
    assign sweep_last  = (delta_q == DW'(DELTA_LAST));
    assign first_delta = (delta_q == DW'(DELTA_START));
    assign acc_clr     = load_last || ((state == S_COMPARE) && !sweep_last);

    always_ff @(posedge i_50M_clk or posedge i_rst) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:     if (bus.i_start) state_nx = S_LOAD_REF;
            S_LOAD_REF: if (load_last) state_nx = S_SCAN;
            S_SCAN:     if (scan_last) state_nx = S_DRAIN;
            S_DRAIN:    if (drain_cnt) state_nx = S_COMPARE;
            S_COMPARE:  state_nx = sweep_last ? S_DONE : S_SCAN;
            S_DONE:     if (bus.i_start) state_nx = S_LOAD_REF;
            default:    state_nx = S_IDLE;
        endcase
    end

    // ref_q is read while the index is presented so it lines up with
    // the ring-buffer sample arriving one cycle later.
    always_ff @(posedge i_50M_clk or posedge i_rst) begin
        if (i_rst) begin
            ref_cnt    <= '0;
            ref_q      <= '0;
            scan_d1    <= 1'b0;
            drain_cnt  <= 1'b0;
            delta_q    <= DW'(DELTA_START);
            index_q    <= '0;
            best_delta <= '0;
            best_corr  <= '0;
            for (int i = 0; i < L; i++)
                ref_mem[i] <= '0;
        end else begin
            scan_d1   <= (state == S_SCAN);
            ref_q     <= ref_mem[index_q];
            drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (bus.i_start)
                        ref_cnt <= '0;
                end
                S_LOAD_REF: begin
                    if (bus.i_ref_valid) begin
                        ref_mem[ref_cnt] <= bus.i_ref_data;
                        ref_cnt          <= ref_cnt + 1'b1;
                    end
                    if (load_last) begin
                        delta_q <= DW'(DELTA_START);
                        index_q <= '0;
                    end
                end
                S_SCAN: index_q <= index_q + 1'b1;
                S_COMPARE: begin
                    if ((acc > best_corr) || first_delta) begin
                        best_corr  <= acc;
                        best_delta <= delta_q;
                    end
                    if (!sweep_last) begin
                        delta_q <= delta_q + 1'b1;
                        index_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    mac_pipe u_mac (
        .i_50M_clk (i_50M_clk),
        .i_rst     (i_rst),
        .clr       (acc_clr),
        .en        (scan_d1),
        .a         (bus.i_buffer_data),
        .b         (ref_q),
        .acc       (acc)
    );

    assign bus.o_delta      = delta_q;
    assign bus.o_index      = index_q;
    assign bus.o_best_delta = best_delta;
    assign bus.o_best_corr  = best_corr;
    assign bus.o_done       = (state == S_DONE);
    assign bus.o_busy       = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_xcorr_delay_scanner.sv
// Directed bench for xcorr_delay_scanner with a registered ring-buffer model.
// Expected results are hand-computed per stimulus pattern.
module tb_xcorr_delay_scanner;
    import onephoto_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    xcorr_delay_scanner_if bus ();

    xcorr_delay_scanner dut (
        .i_50M_clk (clk),
        .i_rst     (rst),
        .bus       (bus)
    );

    sample_t rref [L];
    sample_t bmem [128][L];
    int      n_chk     = 0;
    int      n_fail    = 0;
    int      range_err = 0;

    always @(posedge clk)
        bus.i_buffer_data <= bmem[bus.o_delta][bus.o_index];

    always @(negedge clk)
        if (bus.o_busy === 1'b1
            && (int'(bus.o_delta) < DELTA_START
                || int'(bus.o_delta) > DELTA_LAST))
            range_err++;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_pat();
        for (int d = 0; d < 128; d++)
            for (int i = 0; i < L; i++)
                bmem[d][i] = '0;
        for (int i = 0; i < L; i++)
            rref[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input string tag, input bit gaps);
        bit was_done;
        was_done = bus.o_done;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        if (was_done)
            chk({tag, "_done_drop"}, bus.o_done, 0);
        chk({tag, "_busy"}, bus.o_busy, 1);
        for (int i = 0; i < L; i++) begin
            if (gaps)
                repeat ($urandom_range(0, 3)) tick();
            bus.i_ref_valid = 1'b1;
            bus.i_ref_data  = rref[i];
            tick();
            bus.i_ref_valid = 1'b0;
            bus.i_ref_data  = '0;
        end
    endtask

    task automatic run(input string tag, input bit gaps, input bit disturb,
                       input int exp_delta, input longint exp_corr);
        int n;
        start_load(tag, gaps);
        n = 0;
        while (bus.o_done !== 1'b1 && n < 4000) begin
            bus.i_start     = disturb && (n == 500);
            bus.i_ref_valid = disturb && (n >= 600) && (n < 603);
            bus.i_ref_data  = disturb ? 24'sh7fffff : '0;
            tick();
            n++;
        end
        bus.i_start     = 1'b0;
        bus.i_ref_valid = 1'b0;
        bus.i_ref_data  = '0;
        chk({tag, "_cycles"}, n, 1890);
        chk({tag, "_best_delta"}, bus.o_best_delta, exp_delta);
        chk({tag, "_best_corr"}, bus.o_best_corr, exp_corr);
        repeat (5) tick();
        chk({tag, "_hold_done"}, bus.o_done, 1);
        chk({tag, "_hold_busy"}, bus.o_busy, 0);
        chk({tag, "_hold_delta"}, bus.o_best_delta, exp_delta);
        chk({tag, "_hold_corr"}, bus.o_best_corr, exp_corr);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_delta"}, bus.o_delta, DELTA_START);
        chk({tag, "_index"}, bus.o_index, 0);
        chk({tag, "_best_delta"}, bus.o_best_delta, 0);
        chk({tag, "_best_corr"}, bus.o_best_corr, 0);
        chk({tag, "_done"}, bus.o_done, 0);
        chk({tag, "_busy"}, bus.o_busy, 0);
    endtask

    task automatic pat_impulse();
        clr_pat();
        rref[0]      = 24'sd1000;
        bmem[100][0] = 24'sd1000;
    endtask

    task automatic pat_tie();
        clr_pat();
        rref[0]      = 24'sd50;
        rref[5]      = -24'sd3;
        bmem[80][0]  = 24'sd100;
        bmem[110][0] = 24'sd100;
        bmem[90][5]  = 24'sd7;
    endtask

    task automatic pat_negfirst();
        clr_pat();
        rref[0] = 24'sd1;
        for (int d = DELTA_START; d <= DELTA_LAST; d++)
            bmem[d][0] = sample_t'(-d);
    endtask

    initial begin
        int  n;
        bit  hit;
        bus.i_start     = 1'b0;
        bus.i_ref_valid = 1'b0;
        bus.i_ref_data  = '0;
        clr_pat();

        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        tick();

        pat_impulse();
        run("impulse", 1'b0, 1'b0, 100, 1000000);

        clr_pat();
        for (int i = 0; i < L; i++) begin
            rref[i]      = 24'sh800000;
            bmem[127][i] = 24'sh800000;
        end
        run("negext", 1'b0, 1'b0, 127, longint'(1) << 51);

        pat_tie();
        run("tie", 1'b0, 1'b0, 80, 5000);

        pat_negfirst();
        run("negfirst", 1'b0, 1'b0, 74, -74);

        pat_impulse();
        run("stall", 1'b1, 1'b1, 100, 1000000);

        pat_negfirst();
        start_load("midrst", 1'b0);
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 3000) begin
            if (bus.o_delta == 7'd90 && bus.o_index == 5'd10)
                hit = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        chk("midrst_reach", hit, 1);
        chk("midrst_pre_busy", bus.o_busy, 1);
        rst = 1'b1;
        #1;
        chk_reset("midrst");
        tick();
        chk_reset("midrst_held");
        rst = 1'b0;
        tick();
        chk("midrst_idle_busy", bus.o_busy, 0);

        pat_tie();
        run("after_rst", 1'b0, 1'b0, 80, 5000);

        chk("delta_range", range_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xcorr_delay_scanner.md
# xcorr_delay_scanner

Downstream consumer of the per-microphone sample ring buffer in the OnePhoto direction-finding path. It captures an L-sample reference window from the reference microphone, then sweeps every candidate delay. For each delay it reads the matching L-sample window from the ring buffer and computes a signed cross-correlation sum, then reports the delay with the largest correlation. The result feeds the angle-mapping and display logic.

## Interface
Parameters:
- L, 32, correlation window length in samples.
- DELTA_START, 74, first candidate delay (inclusive).
- DELTA_LAST, 127, last candidate delay (inclusive); also the ring-buffer delay origin.
- READBIT, 24, sample width (signed two's complement).

Ports:
- i_50M_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse, driven by ring-buffer initial-finish; ignored unless in S_IDLE or S_DONE.
- i_ref_valid  in  1  reference sample strobe, at most one per cycle.
- i_ref_data  in  READBIT  signed reference sample.
- o_delta  out  $clog2(DELTA_LAST)  delay presented to the ring buffer.
- o_index  out  $clog2(L)  sample index within the window presented to the ring buffer.
- i_buffer_data  in  READBIT  signed ring-buffer sample; valid exactly 1 cycle after (o_delta, o_index) is presented.
- o_best_delta  out  $clog2(DELTA_LAST)  winning delay.
- o_best_corr  out  2*READBIT+$clog2(L)  winning correlation value (signed, 53 bits at defaults).
- o_done  out  1  high while results are valid (level, not pulse).
- o_busy  out  1  high in every state other than S_IDLE and S_DONE.

## Operation
State machine:
- S_IDLE: wait for i_start, then go to S_LOAD_REF and clear the reference count.
- S_LOAD_REF: each i_ref_valid writes i_ref_data to ref[cnt] and increments cnt.
  - When the L-th sample is written, set o_delta = DELTA_START, o_index = 0, clear the accumulator, and go to S_SCAN.
- S_SCAN: each cycle present (o_delta, o_index) and increment o_index.
  - After o_index = L-1 is presented, go to S_DRAIN.
- S_DRAIN: 2 cycles to flush the read and multiply pipeline, then go to S_COMPARE.
- S_COMPARE: 1 cycle.
  - If the accumulator is strictly greater than best_corr, or this is the first delay, update best_corr and best_delta.
  - If o_delta == DELTA_LAST, go to S_DONE.
  - Otherwise increment o_delta, clear o_index and the accumulator, and go back to S_SCAN.
- S_DONE: hold o_done = 1 and keep the outputs stable. On i_start, clear o_done and go to S_LOAD_REF.

Datapath rules:
- Pipeline: index presented (cycle t) → i_buffer_data and ref[idx] registered (t+1) → product registered (t+2) → accumulated.
- Product: READBIT×READBIT signed, 2*READBIT bits, never truncated.
- Accumulator: sign-extended to 2*READBIT+$clog2(L) bits, so it cannot overflow over L terms.
- Ties keep the earlier, smaller delay.
- i_ref_valid outside S_LOAD_REF is ignored.
- A stall mid-load (no i_ref_valid) simply waits; there is no timeout.

## Timing
Reset values:
- State S_IDLE.
- o_delta = DELTA_START, o_index = 0.
- o_best_delta = 0, o_best_corr = 0.
- o_done = 0, o_busy = 0.
- Accumulator, reference count and ref[] all cleared.

Cycle counts:
- One delay costs L + 3 cycles (32 scan, 2 drain, 1 compare) = 35 at defaults.
- Full sweep of 54 delays = 1890 cycles from entering S_SCAN to o_done rising.
- o_done rises on the cycle after the final S_COMPARE.

Boundary and corner cases:
- o_best_delta and o_best_corr update only in S_COMPARE and are stable throughout S_DONE.
- i_start during S_LOAD_REF, S_SCAN, S_DRAIN or S_COMPARE is ignored.
- i_rst asserted mid-operation returns every register to its reset value immediately (asynchronously).

## Structure
- Shared package onephoto_pkg holds:
  - constants L, DELTA_START, DELTA_LAST, READBIT, also used by the ring buffer;
  - typedef sample_t (logic signed [READBIT-1:0]);
  - typedef corr_t (accumulator width);
  - the state enum.
- One sub-module, mac_pipe: registered signed multiply plus accumulate, with clear and enable inputs. Everything else stays in the top.

## Test plan
- Reset mid-S_SCAN: assert i_rst at delay 90, index 10 → all outputs return to reset values the same cycle, FSM in S_IDLE, o_busy = 0.
- Impulse match: ref = {1000, 0, ...}; buffer model returns 1000 only at delay 100, index 0, and 0 elsewhere → o_best_delta = 100, o_best_corr = 1_000_000, o_done after 1890 cycles.
- Negative extremes: ref all = -8388608; buffer all = -8388608 at delay 127, 0 elsewhere → o_best_corr = 32×2^46 = 2^51, no overflow, o_best_delta = 127.
- Tie: identical correlation 5000 at delays 80 and 110 → o_best_delta = 80.
- Ref load stall: deliver 32 reference samples with random gaps; drive i_start mid-scan and pulse i_ref_valid during S_SCAN → ignored. Result matches the gap-free run; o_index always in 0..31, and o_delta in 74..127 throughout S_SCAN.
- Restart: after o_done, pulse i_start with a new reference set → o_done drops next cycle, second result matches the golden model.
